timestep_sequencer: RTL

- Parametrised timestep controller for the SNN accelerator. It replaces the fixed 4-cycle clear generator with a controller that has:
  - a programmable period,
  - bounded or unbounded runs,
  - per-group completion handshake,
  - overrun/stall reporting.
- It drives the `clear` input of the accelerator and the neuron groups.
- It collects a done strobe from each enabled neuron group before it advances the timestep.

---
 rtl/timestep_sequencer.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/timestep_sequencer.sv
// Timestep controller for the SNN accelerator: issues a clear pulse per timestep,
// waits for neuron-group completion in handshake mode, and reports overrun/stall.
module timestep_sequencer #(
  parameter int unsigned NUM_GROUPS = 10,
  parameter int unsigned PERIOD_W   = 4,
  parameter int unsigned TS_W       = 16,
  parameter int unsigned STALL_W    = 16
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  mode,
  input  logic [PERIOD_W-1:0]   period,
  input  logic [TS_W-1:0]       max_timesteps,
  input  logic [NUM_GROUPS-1:0] group_mask,
  input  logic [NUM_GROUPS-1:0] group_done,
  output logic                  clear,
  output logic                  busy,
  output logic [TS_W-1:0]       timestep,
  output logic                  finished,
  output logic                  overrun,
  output logic [STALL_W-1:0]    stall_cycles
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_RUN,
    ST_WAIT_DONE,
    ST_DONE
  } state_e;

  localparam logic [PERIOD_W-1:0] MIN_PERIOD = PERIOD_W'(2);

  state_e                state_q,       state_d;
  logic [PERIOD_W-1:0]   period_q,      period_d;
  logic                  mode_q,        mode_d;
  logic [TS_W-1:0]       max_q,         max_d;
  logic [NUM_GROUPS-1:0] mask_q,        mask_d;
  logic [PERIOD_W-1:0]   cyc_q,         cyc_d;
  logic [NUM_GROUPS-1:0] done_sticky_q, done_sticky_d;
  logic                  stop_req_q,    stop_req_d;
  logic [TS_W-1:0]       timestep_q,    timestep_d;
  logic                  overrun_q,     overrun_d;
  logic [STALL_W-1:0]    stall_q,       stall_d;

  logic                  all_done;
  logic                  ts_end;
  logic [TS_W-1:0]       ts_inc;
  logic                  hit_max;

  // The current-cycle strobe counts too, so a group finishing on the last cycle is on time.
  assign all_done = (((done_sticky_q | group_done) & mask_q) == mask_q);
  assign ts_inc   = timestep_q + 1'b1;
  assign hit_max  = (max_q != '0) && (ts_inc == max_q);

  always_comb begin
    state_d       = state_q;
    period_d      = period_q;
    mode_d        = mode_q;
    max_d         = max_q;
    mask_d        = mask_q;
    cyc_d         = cyc_q;
    done_sticky_d = done_sticky_q;
    stop_req_d    = stop_req_q;
    timestep_d    = timestep_q;
    overrun_d     = overrun_q;
    stall_d       = stall_q;
    ts_end        = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          period_d   = (period < MIN_PERIOD) ? MIN_PERIOD : period;
          mode_d     = mode;
          max_d      = max_timesteps;
          mask_d     = group_mask;
          timestep_d = '0;
          overrun_d  = 1'b0;
          stall_d    = '0;
          stop_req_d = 1'b0;
          state_d    = ST_CLEAR;
        end
      end

      ST_CLEAR: begin
        cyc_d         = PERIOD_W'(1);
        done_sticky_d = '0;
        if (stop) stop_req_d = 1'b1;
        state_d = ST_RUN;
      end

      ST_RUN: begin
        done_sticky_d = done_sticky_q | (group_done & mask_q);
        cyc_d         = cyc_q + 1'b1;
        if (stop) stop_req_d = 1'b1;
        if (cyc_q == period_q - 1'b1) begin
          if (!mode_q) begin
            if (!all_done) overrun_d = 1'b1;
            ts_end = 1'b1;
          end else if (all_done) begin
            ts_end = 1'b1;
          end else begin
            state_d = ST_WAIT_DONE;
          end
        end
      end

      ST_WAIT_DONE: begin
        done_sticky_d = done_sticky_q | (group_done & mask_q);
        if (stall_q != '1) stall_d = stall_q + 1'b1;
        if (stop) stop_req_d = 1'b1;
        if (all_done) ts_end = 1'b1;
      end

      ST_DONE: begin
        stop_req_d = 1'b0;
        state_d    = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase

    // A stop seen in the ending cycle itself still terminates the run here.
    if (ts_end) begin
      timestep_d = ts_inc;
      if (stop_req_q || stop || hit_max) state_d = ST_DONE;
      else                               state_d = ST_CLEAR;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q       <= ST_IDLE;
      period_q      <= '0;
      mode_q        <= 1'b0;
      max_q         <= '0;
      mask_q        <= '0;
      cyc_q         <= '0;
      done_sticky_q <= '0;
      stop_req_q    <= 1'b0;
      timestep_q    <= '0;
      overrun_q     <= 1'b0;
      stall_q       <= '0;
    end else begin
      state_q       <= state_d;
      period_q      <= period_d;
      mode_q        <= mode_d;
      max_q         <= max_d;
      mask_q        <= mask_d;
      cyc_q         <= cyc_d;
      done_sticky_q <= done_sticky_d;
      stop_req_q    <= stop_req_d;
      timestep_q    <= timestep_d;
      overrun_q     <= overrun_d;
      stall_q       <= stall_d;
    end
  end

  assign clear        = (state_q == ST_CLEAR);
  assign busy         = (state_q != ST_IDLE);
  assign finished     = (state_q == ST_DONE);
  assign timestep     = timestep_q;
  assign overrun      = overrun_q;
  assign stall_cycles = stall_q;

endmodule
